slave_mem_wr_arb: RTL and testbench

- Round-robin, burst-locked arbiter that shares one memory-model write port between NUM_REQ slave write queues (e.g. DBB and CVSRAM slave queues) in the synth testbench.
- Each requester presents the head entry of its write queue: valid, word address, data, mask and AXI len.
- The arbiter grants one requester and holds the grant until len+1 beats have transferred, then rotates priority.
- It sits between the per-slave write queues and the single memory write port.

---
 rtl/slave_mem_wr_arb_pkg.sv | 8 +
 rtl/slave_mem_wr_arb_rr_pick.sv | 22 ++
 rtl/slave_mem_wr_arb.sv | 99 +++++++++
 tb/tb_slave_mem_wr_arb.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/slave_mem_wr_arb_pkg.sv
// slave_mem_wr_arb_pkg: default widths and arbiter state encoding shared by the write-port arbiter files.
package slave_mem_wr_arb_pkg;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_MASK_W = 4;
  localparam int DEF_LEN_W  = 4;
  typedef enum logic {ARB_IDLE = 1'b0, ARB_BURST = 1'b1} arb_state_e;
endpackage

// File: rtl/slave_mem_wr_arb_rr_pick.sv
// slave_mem_wr_arb_rr_pick: combinational round-robin picker, first requester after i_last wins.
module slave_mem_wr_arb_rr_pick #(
  parameter int N    = 2,
  parameter int ID_W = 1
) (
  input  logic [N-1:0]    i_req,
  input  logic [ID_W-1:0] i_last,
  output logic            o_vld,
  output logic [ID_W-1:0] o_idx
);
  // Scan farthest offset first so the nearest valid requester is assigned last and wins.
  always_comb begin
    o_vld = 1'b0;
    o_idx = '0;
    for (int k = N; k >= 1; k--) begin
      if (i_req[(int'(i_last) + k) % N]) begin
        o_vld = 1'b1;
        o_idx = ID_W'((int'(i_last) + k) % N);
      end
    end
  end
endmodule

// File: rtl/slave_mem_wr_arb.sv
// slave_mem_wr_arb: round-robin, burst-locked arbiter sharing one memory write port between NUM_REQ write queues.
module slave_mem_wr_arb
  import slave_mem_wr_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MASK_W  = DEF_MASK_W,
  parameter int LEN_W   = DEF_LEN_W
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  input  logic [NUM_REQ*MASK_W-1:0] i_req_mask,
  input  logic [NUM_REQ*LEN_W-1:0]  i_req_len,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic                      o_mem_wr_vld,
  output logic [ADDR_W-1:0]         o_mem_wr_addr,
  output logic [DATA_W-1:0]         o_mem_wr_data,
  output logic [MASK_W-1:0]         o_mem_wr_mask,
  output logic                      o_mem_wr_last,
  input  logic                      i_mem_wr_ready,
  output logic [ID_W-1:0]           o_grant_id,
  output logic                      o_busy,
  output logic                      o_err_len_change
);
  arb_state_e       r_state, w_state_nxt;
  logic [ID_W-1:0]  r_gnt, r_last_gnt, w_gnt_nxt, w_last_gnt_nxt, w_sel, w_gnt;
  logic [LEN_W-1:0] r_beat_cnt, r_burst_len, w_beat_cnt_nxt, w_burst_len_nxt, w_len;
  logic             r_err, w_err_nxt, w_sel_vld, w_burst, w_vld, w_xfer;

  slave_mem_wr_arb_rr_pick #(.N(NUM_REQ), .ID_W(ID_W)) u_pick (
    .i_req  (i_req_valid),
    .i_last (r_last_gnt),
    .o_vld  (w_sel_vld),
    .o_idx  (w_sel)
  );

  assign w_burst = r_state == ARB_BURST;
  assign w_gnt   = w_burst ? r_gnt : w_sel;
  assign w_len   = i_req_len[int'(w_gnt)*LEN_W +: LEN_W];
  // Gated by reset so a valid queue head cannot leak a beat while the arbiter is held in reset.
  assign w_vld   = i_rst_n && (w_burst ? i_req_valid[w_gnt] : w_sel_vld);
  assign w_xfer  = w_vld && i_mem_wr_ready;

  assign o_mem_wr_vld     = w_vld;
  assign o_mem_wr_addr    = i_req_addr[int'(w_gnt)*ADDR_W +: ADDR_W];
  assign o_mem_wr_data    = i_req_data[int'(w_gnt)*DATA_W +: DATA_W];
  assign o_mem_wr_mask    = i_req_mask[int'(w_gnt)*MASK_W +: MASK_W];
  assign o_mem_wr_last    = w_vld && (w_burst ? r_beat_cnt == r_burst_len : w_len == '0);
  assign o_req_ready      = w_xfer ? NUM_REQ'(1) << w_gnt : '0;
  assign o_grant_id       = w_gnt;
  assign o_busy           = i_rst_n && w_burst;
  assign o_err_len_change = r_err;

  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = r_gnt;
    w_last_gnt_nxt  = r_last_gnt;
    w_beat_cnt_nxt  = r_beat_cnt;
    w_burst_len_nxt = r_burst_len;
    w_err_nxt       = r_err || (w_burst && i_req_valid[r_gnt] && w_len != r_burst_len);
    if (w_xfer && !w_burst) begin
      if (w_len == '0) begin
        w_last_gnt_nxt = w_sel;
      end else begin
        w_state_nxt     = ARB_BURST;
        w_gnt_nxt       = w_sel;
        w_burst_len_nxt = w_len;
        w_beat_cnt_nxt  = LEN_W'(1);
      end
    end else if (w_xfer) begin
      w_state_nxt    = o_mem_wr_last ? ARB_IDLE : ARB_BURST;
      w_beat_cnt_nxt = o_mem_wr_last ? '0 : r_beat_cnt + LEN_W'(1);
      w_last_gnt_nxt = o_mem_wr_last ? r_gnt : r_last_gnt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ARB_IDLE;
      r_gnt       <= '0;
      r_last_gnt  <= ID_W'(NUM_REQ - 1);
      r_beat_cnt  <= '0;
      r_burst_len <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_last_gnt  <= w_last_gnt_nxt;
      r_beat_cnt  <= w_beat_cnt_nxt;
      r_burst_len <= w_burst_len_nxt;
      r_err       <= w_err_nxt;
    end
  end
endmodule

// File: tb/tb_slave_mem_wr_arb.sv
// tb_slave_mem_wr_arb: directed scenarios plus randomized traffic against a burst-level reference model.
module tb_slave_mem_wr_arb;
  localparam int N = 3, IDW = 2, AW = 16, DW = 32, MW = 4, LW = 4;

  logic clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b0;
  logic [N-1:0] valid = '0;
  logic [AW-1:0] addr_a[N];
  logic [DW-1:0] data_a[N];
  logic [MW-1:0] mask_a[N];
  logic [LW-1:0] len_a[N];
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N*MW-1:0] req_mask;
  logic [N*LW-1:0] req_len;
  logic [N-1:0] req_ready;
  logic mem_vld, mem_last, busy, err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [MW-1:0] mem_mask;
  logic [IDW-1:0] grant_id;
  int checks = 0, errors = 0;

  // Reference model: owner of the open burst and beats still owed
  bit m_busy, m_err, exp_vld, exp_last;
  int m_owner, m_left, m_prio, m_blen, exp_gnt;
  logic [N-1:0] exp_ready;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_flat
    assign req_addr[g*AW +: AW] = addr_a[g];
    assign req_data[g*DW +: DW] = data_a[g];
    assign req_mask[g*MW +: MW] = mask_a[g];
    assign req_len[g*LW +: LW]  = len_a[g];
  end

  slave_mem_wr_arb #(.NUM_REQ(N), .ID_W(IDW), .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .LEN_W(LW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(valid), .i_req_addr(req_addr), .i_req_data(req_data),
    .i_req_mask(req_mask), .i_req_len(req_len), .o_req_ready(req_ready), .o_mem_wr_vld(mem_vld),
    .o_mem_wr_addr(mem_addr), .o_mem_wr_data(mem_data), .o_mem_wr_mask(mem_mask), .o_mem_wr_last(mem_last),
    .i_mem_wr_ready(mem_ready), .o_grant_id(grant_id), .o_busy(busy), .o_err_len_change(err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      addr_a[i] = AW'($urandom);
      data_a[i] = $urandom;
      mask_a[i] = MW'($urandom);
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    valid = '0;
    mem_ready = 1'b1;
    for (int i = 0; i < N; i++) len_a[i] = '0;
    m_busy = 0; m_err = 0; m_prio = N - 1; m_owner = 0; m_left = 0; m_blen = 0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic model_eval;
    exp_vld = 0;
    exp_gnt = 0;
    if (m_busy) begin
      exp_gnt = m_owner;
      exp_vld = valid[m_owner];
    end else begin
      for (int k = 1; k <= N; k++)
        if (!exp_vld && valid[(m_prio + k) % N]) begin
          exp_vld = 1;
          exp_gnt = (m_prio + k) % N;
        end
    end
    exp_last = exp_vld && (m_busy ? m_left == 1 : len_a[exp_gnt] == 0);
    exp_ready = (exp_vld && mem_ready) ? N'(1) << exp_gnt : '0;
  endtask

  task automatic model_commit;
    if (m_busy && valid[m_owner] && int'(len_a[m_owner]) != m_blen) m_err = 1;
    if (exp_vld && mem_ready) begin
      if (!m_busy) begin
        if (len_a[exp_gnt] == 0) m_prio = exp_gnt;
        else begin
          m_busy = 1; m_owner = exp_gnt; m_blen = int'(len_a[exp_gnt]); m_left = m_blen;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0;
          m_prio = m_owner;
        end
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    valid = '1;
    mem_ready = 1'b1;
    @(negedge clk);
    checks++; if (mem_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b exp 0", mem_vld); end
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready got %b exp 000", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (mem_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b exp 0", mem_last); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
  endtask

  task automatic test_single_rr;
    do_reset();
    valid = 3'b011;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (grant_id !== IDW'(c % 2)) begin errors++; $display("FAIL rr_gnt c=%0d got %0d exp %0d", c, grant_id, c % 2); end
      checks++; if (req_ready !== N'(1 << (c % 2))) begin errors++; $display("FAIL rr_ready c=%0d got %b", c, req_ready); end
      checks++; if (mem_last !== 1'b1) begin errors++; $display("FAIL rr_last c=%0d got %b exp 1", c, mem_last); end
      checks++; if (mem_addr !== addr_a[c % 2] || mem_data !== data_a[c % 2]) begin errors++; $display("FAIL rr_mux c=%0d got %h/%h", c, mem_addr, mem_data); end
      tick();
    end
    valid = '0;
  endtask

  task automatic test_burst_lock;
    do_reset();
    valid = 3'b011;
    len_a[0] = 4'd3;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (req_ready !== (c < 4 ? 3'b001 : 3'b010)) begin errors++; $display("FAIL lock_ready c=%0d got %b", c, req_ready); end
      checks++; if (mem_last !== (c >= 3)) begin errors++; $display("FAIL lock_last c=%0d got %b exp %b", c, mem_last, c >= 3); end
      checks++; if (busy !== (c >= 1 && c <= 3)) begin errors++; $display("FAIL lock_busy c=%0d got %b", c, busy); end
      tick();
    end
    valid = '0;
  endtask

  task automatic test_ready_stall;
    int pat[5] = '{1, 0, 1, 0, 1};
    int xfers = 0;
    do_reset();
    valid = 3'b001;
    len_a[0] = 4'd2;
    for (int c = 0; c < 5; c++) begin
      mem_ready = pat[c][0];
      @(negedge clk);
      if (req_ready[0]) xfers++;
      checks++; if (req_ready !== (pat[c] != 0 ? 3'b001 : 3'b000)) begin errors++; $display("FAIL stall_ready c=%0d got %b", c, req_ready); end
      checks++; if (busy !== (c > 0)) begin errors++; $display("FAIL stall_busy c=%0d got %b exp %b", c, busy, c > 0); end
      checks++; if (mem_last !== (c >= 3)) begin errors++; $display("FAIL stall_last c=%0d got %b exp %b", c, mem_last, c >= 3); end
      tick();
    end
    valid = '0;
    mem_ready = 1'b1;
    @(negedge clk);
    checks++; if (xfers != 3) begin errors++; $display("FAIL stall_xfers got %0d exp 3", xfers); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_end_busy got %b exp 0", busy); end
    tick();
  endtask

  task automatic test_valid_drop;
    do_reset();
    valid = 3'b011;
    len_a[0] = 4'd3;
    @(negedge clk);
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL drop_first got %b exp 001", req_ready); end
    tick();
    valid[0] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (mem_vld !== 1'b0 || req_ready !== '0 || busy !== 1'b1) begin errors++; $display("FAIL drop_wait c=%0d got vld=%b rdy=%b busy=%b", c, mem_vld, req_ready, busy); end
      tick();
    end
    valid[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (req_ready !== 3'b001 || mem_last !== (c == 2)) begin errors++; $display("FAIL drop_rest c=%0d got rdy=%b last=%b", c, req_ready, mem_last); end
      tick();
    end
    @(negedge clk);
    checks++; if (req_ready !== 3'b010 || grant_id !== 2'd1) begin errors++; $display("FAIL drop_next got rdy=%b gnt=%0d exp 010/1", req_ready, grant_id); end
    tick();
    valid = '0;
  endtask

  task automatic test_len_change;
    do_reset();
    valid = 3'b001;
    len_a[0] = 4'd3;
    tick();
    len_a[0] = 4'd5;
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      checks++; if (err !== (c >= 2)) begin errors++; $display("FAIL len_err c=%0d got %b exp %b", c, err, c >= 2); end
      checks++; if (req_ready !== 3'b001 || mem_last !== (c == 3)) begin errors++; $display("FAIL len_beat c=%0d got rdy=%b last=%b", c, req_ready, mem_last); end
      tick();
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || err !== 1'b1) begin errors++; $display("FAIL len_end got busy=%b err=%b exp 0/1", busy, err); end
    tick();
    valid = '0;
    tick();
    @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL len_sticky got %b exp 1", err); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    valid = 3'b011;
    len_a[0] = 4'd3;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (mem_vld !== 1'b0 || req_ready !== '0 || busy !== 1'b0 || mem_last !== 1'b0) begin errors++; $display("FAIL midrst_out got vld=%b rdy=%b busy=%b last=%b", mem_vld, req_ready, busy, mem_last); end
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (mem_vld !== 1'b1 || grant_id !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_regrant got vld=%b gnt=%0d busy=%b exp 1/0/0", mem_vld, grant_id, busy); end
    tick();
    valid = '0;
  endtask

  task automatic test_random;
    int rem[N];
    int glen[N];
    do_reset();
    for (int i = 0; i < N; i++) begin rem[i] = 0; glen[i] = 0; end
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0 && $urandom_range(1, 0) == 1) begin
          glen[i] = $urandom_range(3, 0);
          rem[i] = glen[i] + 1;
        end
        valid[i] = rem[i] > 0 && $urandom_range(9, 0) < 8;
        len_a[i] = LW'(glen[i]);
      end
      mem_ready = $urandom_range(3, 0) != 0;
      @(negedge clk);
      model_eval();
      checks++; if (mem_vld !== exp_vld) begin errors++; $display("FAIL rnd_vld c=%0d got %b exp %b", c, mem_vld, exp_vld); end
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready c=%0d got %b exp %b", c, req_ready, exp_ready); end
      checks++; if (mem_last !== exp_last) begin errors++; $display("FAIL rnd_last c=%0d got %b exp %b", c, mem_last, exp_last); end
      checks++; if (busy !== m_busy || err !== m_err) begin errors++; $display("FAIL rnd_state c=%0d got busy=%b err=%b exp %b/%b", c, busy, err, m_busy, m_err); end
      if (exp_vld) begin
        checks++;
        if (grant_id !== IDW'(exp_gnt) || mem_addr !== addr_a[exp_gnt] || mem_data !== data_a[exp_gnt] || mem_mask !== mask_a[exp_gnt]) begin
          errors++;
          $display("FAIL rnd_mux c=%0d got gnt=%0d addr=%h exp gnt=%0d addr=%h", c, grant_id, mem_addr, exp_gnt, addr_a[exp_gnt]);
        end
        if (mem_ready) rem[exp_gnt]--;
      end
      model_commit();
      tick();
    end
    valid = '0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin addr_a[i] = '0; data_a[i] = '0; mask_a[i] = '0; len_a[i] = '0; end
    test_reset();
    test_single_rr();
    test_burst_lock();
    test_ready_stall();
    test_valid_drop();
    test_len_change();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
